// File: rtl/seven_seg_scan_driver.sv
// ============================================================================
// seven_seg_scan_driver
// ----------------------------------------------------------------------------
// Multiplexed 7-segment display driver. The divided scan clock from
// Clock_Divider arrives on slow_clk as plain data. It is synchronized into
// the clk_in domain. Each rising edge advances the scan by one digit.
//
// A new hex word is captured as "pending". It is moved into the displayed
// word only when the scan wraps from the last digit back to digit 0, so a
// frame never shows a mix of old and new data.
//
// All outputs are active-low and registered, ready to drive board pins.
//
// Parameters
//   NUM_DIGITS   digits scanned (1..8); value is 4*NUM_DIGITS bits wide
//   SYNC_STAGES  synchronizer flops on slow_clk (>= 2)
//   DP_MASK      bit i = 1 lights the decimal point on digit i
//
// Ports
//   clk_in       system clock, all logic on posedge
//   reset        synchronous, active-high
//   slow_clk     scan clock, asynchronous to clk_in
//   value        hex word; nibble i is shown on digit i (digit 0 = rightmost)
//   value_valid  strobe: capture value as pending (the last strobe wins)
//   digit_en     per-digit enable; 0 keeps that anode off
//   an           anodes, active-low, one-hot-low
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low
//   frame_done   1-cycle pulse after the scan wraps to digit 0
//
// Optional feature
//   SEVSEG_BLANK_LEADING_ZEROS_EN
//     When defined, digit i (i > 0) is blanked when nibbles i..NUM_DIGITS-1
//     of the displayed word are all zero and DP_MASK[i] is 0.
//     Digit 0 is never blanked.
//     When undefined, every enabled digit shows its nibble.
// ============================================================================
module seven_seg_scan_driver #(
  parameter int         NUM_DIGITS  = 8,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DP_MASK     = 8'h00
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    slow_clk,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    value_valid,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int              VAL_W    = 4 * NUM_DIGITS;
  localparam int              IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   scan_tick;
  logic                   wrap;

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_next;
  logic [VAL_W-1:0] disp_q;
  logic [VAL_W-1:0] disp_next;
  logic [VAL_W-1:0] pend_val_q;
  logic [VAL_W-1:0] pend_val_next;
  logic             pend_flag_q;
  logic             pend_flag_next;

  logic [3:0]            nibble;
  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            seg_next;
  logic                  dp_next;

  // slow_clk is asynchronous to clk_in.
  // It goes through a flop chain, then one more flop for edge detection.
  // Falling edges are ignored.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign scan_tick = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign wrap      = scan_tick && (idx_q == LAST_IDX);

  // Compute the next scan position, displayed word and pending word.
  // A strobe that lands exactly on the wrap goes straight to the display.
  // Otherwise, any pending word is promoted to the display at the wrap.
  always_comb begin
    idx_next       = idx_q;
    disp_next      = disp_q;
    pend_val_next  = pend_val_q;
    pend_flag_next = pend_flag_q;

    if (scan_tick) begin
      idx_next = wrap ? '0 : idx_q + IDX_W'(1);
    end

    if (value_valid) begin
      pend_val_next  = value;
      pend_flag_next = 1'b1;
    end

    if (wrap) begin
      if (value_valid) begin
        disp_next = value;
      end else if (pend_flag_q) begin
        disp_next = pend_val_q;
      end
      pend_flag_next = 1'b0;
    end
  end

`ifdef SEVSEG_BLANK_LEADING_ZEROS_EN
  logic [NUM_DIGITS-1:0] upper_zero;

  // upper_zero[i]: every nibble from digit i upward is zero
  always_comb begin
    upper_zero = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      upper_zero[i] = ((disp_next >> (4 * i)) == VAL_W'(0));
    end
  end
`endif

  // Output decode.
  // It uses the post-update index and word, so the pins change on the
  // same clk_in edge as the scan position.
  always_comb begin
    nibble = disp_next[{idx_next, 2'b00} +: 4];

    an_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_next[i] = ~((idx_next == IDX_W'(i)) && digit_en[i]);
    end

    seg_next = ~hex7(nibble);
    dp_next  = ~DP_MASK[idx_next];

`ifdef SEVSEG_BLANK_LEADING_ZEROS_EN
    if ((idx_next != '0) && upper_zero[idx_next] && !DP_MASK[idx_next]) begin
      an_next  = '1;
      seg_next = 7'h7F;
      dp_next  = 1'b1;
    end
`endif
  end

  // Scan state and registered pin drivers.
  // A reset aborts the frame and drops any pending word.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      idx_q       <= '0;
      disp_q      <= '0;
      pend_val_q  <= '0;
      pend_flag_q <= 1'b0;
      an          <= '1;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      idx_q       <= idx_next;
      disp_q      <= disp_next;
      pend_val_q  <= pend_val_next;
      pend_flag_q <= pend_flag_next;
      an          <= an_next;
      seg         <= seg_next;
      dp          <= dp_next;
      frame_done  <= wrap;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// ============================================================================
// tb_seven_seg_scan_driver
// ----------------------------------------------------------------------------
// Self-checking bench for seven_seg_scan_driver (8 digits, DP on digit 0).
// Every slow_clk edge pushes the expected pin state into a scoreboard
// queue. The queue is popped when the registered outputs should have
// updated.
// The same file covers the SEVSEG_BLANK_LEADING_ZEROS_EN build.
// ============================================================================
module tb_seven_seg_scan_driver;

  localparam logic [7:0] DP = 8'h01;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        slow_clk;
  logic [31:0] value;
  logic        value_valid;
  logic [7:0]  digit_en;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  int          m_idx;
  logic [31:0] m_disp;
  logic [31:0] m_pend_val;
  bit          m_pend;
  logic [7:0]  last_an;
  exp_t        sb[$];

  seven_seg_scan_driver #(
    .NUM_DIGITS (8),
    .SYNC_STAGES(2),
    .DP_MASK    (DP)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .slow_clk   (slow_clk),
    .value      (value),
    .value_valid(value_valid),
    .digit_en   (digit_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Expected pin state for the model's current digit and word
  function automatic exp_t modelOut(input logic fd);
    exp_t       e;
    logic [3:0] nib;
    nib   = m_disp[4*m_idx +: 4];
    e.an  = 8'hFF;
    if (digit_en[m_idx]) e.an[m_idx] = 1'b0;
    e.seg = ~SEG_TAB[nib];
    e.dp  = ~DP[m_idx];
    e.fd  = fd;
`ifdef SEVSEG_BLANK_LEADING_ZEROS_EN
    if (m_idx > 0 && (m_disp >> (4 * m_idx)) == 32'h0 && !DP[m_idx]) begin
      e.an  = 8'hFF;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic checkHead(input string tag);
    exp_t e;
    e = sb.pop_front();
    checkOutput({tag, " an"}, 32'(an), 32'(e.an));
    checkOutput({tag, " seg"}, 32'(seg), 32'(e.seg));
    checkOutput({tag, " dp"}, 32'(dp), 32'(e.dp));
    checkOutput({tag, " frame_done"}, 32'(frame_done), 32'(e.fd));
    last_an = e.an;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " an"}, 32'(an), 32'hFF);
    checkOutput({tag, " seg"}, 32'(seg), 32'h7F);
    checkOutput({tag, " dp"}, 32'(dp), 32'h1);
    checkOutput({tag, " frame_done"}, 32'(frame_done), 32'h0);
  endtask

  // One slow_clk rising edge.
  // The optional strobe is timed to land in the scan_tick cycle.
  task automatic applyStimulus(input bit strobe, input logic [31:0] v, input string tag);
    bit is_wrap;
    is_wrap = (m_idx == 7);
    if (is_wrap) begin
      if (strobe) m_disp = v;
      else if (m_pend) m_disp = m_pend_val;
      m_pend = 1'b0;
      m_idx  = 0;
    end else begin
      m_idx++;
      if (strobe) begin
        m_pend_val = v;
        m_pend     = 1'b1;
      end
    end
    sb.push_back(modelOut(is_wrap));

    @(negedge clk_in) slow_clk = 1'b1;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    checkOutput({tag, " latency an"}, 32'(an), 32'(last_an));
    if (strobe) begin
      value       = v;
      value_valid = 1'b1;
    end
    @(posedge clk_in);
    #1;
    value_valid = 1'b0;
    checkHead(tag);
    @(posedge clk_in);
    #1;
    checkOutput({tag, " frame_done width"}, 32'(frame_done), 32'h0);
    @(negedge clk_in) slow_clk = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    checkOutput({tag, " falling edge ignored"}, 32'(an), 32'(last_an));
  endtask

  task automatic strobeMid(input logic [31:0] v);
    @(negedge clk_in);
    value       = v;
    value_valid = 1'b1;
    @(negedge clk_in);
    value_valid = 1'b0;
    m_pend_val  = v;
    m_pend      = 1'b1;
  endtask

  task automatic settle(input string tag);
    sb.push_back(modelOut(1'b0));
    repeat (2) @(posedge clk_in);
    #1;
    checkHead(tag);
  endtask

  initial begin
    reset       = 1'b1;
    slow_clk    = 1'b0;
    value       = 32'h0;
    value_valid = 1'b0;
    digit_en    = 8'hFF;
    m_idx       = 0;
    m_disp      = 32'h0;
    m_pend_val  = 32'h0;
    m_pend      = 1'b0;
    last_an     = 8'hFF;

    $display("[TB] reset held with slow_clk toggling");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in) slow_clk = ~slow_clk;
      @(posedge clk_in);
      #1;
      checkResetState("reset");
    end

    @(negedge clk_in);
    slow_clk    = 1'b0;
    reset       = 1'b0;
    value       = 32'h0;
    value_valid = 1'b1;
    m_pend      = 1'b1;
    m_pend_val  = 32'h0;
    sb.push_back(modelOut(1'b0));
    @(posedge clk_in);
    #1;
    value_valid = 1'b0;
    checkHead("post reset");

    $display("[TB] full scan of zeros");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, "scan");

    $display("[TB] tear-free update");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, "tear pre");
    strobeMid(32'h1234_5678);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 32'h0, "tear");

    $display("[TB] strobe on wrap");
    strobeMid(32'hAAAA_AAAA);
    applyStimulus(1'b1, 32'hBBBB_BBBB, "wrap collision");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, "after collision");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, "last wins pre");
    strobeMid(32'hCCCC_CCCC);
    strobeMid(32'h9E3D_0F51);
    for (int i = 0; i < 13; i++) applyStimulus(1'b0, 32'h0, "last wins");

    $display("[TB] digit enables and decimal point");
    digit_en = 8'h0F;
    settle("enable change");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, "enables");
    digit_en = 8'hFF;
    settle("enable restore");

    $display("[TB] leading zeros and mid-frame reset");
    strobeMid(32'h0000_00C0);
    for (int i = 0; i < 13; i++) applyStimulus(1'b0, 32'h0, "leading zeros");
    strobeMid(32'hFFFF_FFFF);
    @(negedge clk_in) reset = 1'b1;
    @(posedge clk_in);
    #1;
    checkResetState("mid reset");
    @(negedge clk_in) reset = 1'b0;
    m_idx  = 0;
    m_disp = 32'h0;
    m_pend = 1'b0;
    sb.push_back(modelOut(1'b0));
    @(posedge clk_in);
    #1;
    checkHead("restart");
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, "after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
